// File: rtl/sch_issue_ctl_if.sv
// Issue/hazard controller bus.
// Groups the decode-side instruction fields and the downstream controls into
// one bundle. The hazard-control results go back to the pipeline registers.
//   master : drives decode fields, ext_stall, alu_mispredict; receives controls
//   slave  : the controller; receives decode fields, drives stall/flush/issue
interface sch_issue_ctl_if;
    logic        dec_valid;
    logic        dec_uses_rs;
    logic [4:0]  dec_rs_addr;
    logic        dec_uses_rt;
    logic [4:0]  dec_rt_addr;
    logic        dec_uses_rw;
    logic [4:0]  dec_rw_addr;
    logic        dec_is_load;
    logic        ext_stall;
    logic        alu_mispredict;
    logic        up_stall;
    logic        up_flush;
    logic        sch_stall;
    logic        sch_flush;
    logic        issue;
    logic [31:0] busy_mask;

    modport master (
        output dec_valid, dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
               dec_uses_rw, dec_rw_addr, dec_is_load, ext_stall, alu_mispredict,
        input  up_stall, up_flush, sch_stall, sch_flush, issue, busy_mask
    );

    modport slave (
        input  dec_valid, dec_uses_rs, dec_rs_addr, dec_uses_rt, dec_rt_addr,
               dec_uses_rw, dec_rw_addr, dec_is_load, ext_stall, alu_mispredict,
        output up_stall, up_flush, sch_stall, sch_flush, issue, busy_mask
    );
endinterface

// File: rtl/sch_issue_ctl.sv
// Issue/hazard controller for the scheduling stage.
// Keeps a per-register load-use countdown scoreboard and produces the stall /
// flush controls for the fetch/decode registers and the scheduling register.
// Ports:
//   clk    : clock
//   rst_n  : synchronous reset, active low (all outputs forced 0 while low)
//   bus    : sch_issue_ctl_if.slave (decode fields, ext_stall, alu_mispredict
//            in; up_stall, up_flush, sch_stall, sch_flush, issue, busy_mask out)
//
// Control priority (combinational):
//   state          | meaning
//   stall          | ext_stall: freeze everything, remember any mispredict
//   flush          | mispredict now or deferred: flush both registers
//   bubble         | load-use hazard: hold decode, insert bubble
//   issue          | decode instruction advances into scheduling register
module sch_issue_ctl #(
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sch_issue_ctl_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LOAD_LAT);

    logic [CNT_W-1:0] cnt_q [1:31];
    logic [CNT_W-1:0] cnt_d [1:31];
    logic             pend_flush_q, pend_flush_d;
    logic             sch_load_vld_q, sch_load_vld_d;
    logic [4:0]       sch_load_rw_q, sch_load_rw_d;

    logic [31:0] busy_vec;
    logic        haz;
    logic        flush_req;
    logic        flush_take;
    logic        issue_c;
    logic        load_set;

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < 32; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    // busy_vec[0] is constant 0, so r0 never hazards.
    assign haz = bus.dec_valid &
                 ((bus.dec_uses_rs & busy_vec[bus.dec_rs_addr]) |
                  (bus.dec_uses_rt & busy_vec[bus.dec_rt_addr]));

    assign flush_req  = bus.alu_mispredict | pend_flush_q;
    assign flush_take = ~bus.ext_stall & flush_req;
    assign issue_c    = ~bus.ext_stall & ~flush_req & ~haz & bus.dec_valid;
    assign load_set   = issue_c & bus.dec_is_load & bus.dec_uses_rw &
                        (bus.dec_rw_addr != 5'd0);

    always_comb begin
        bus.up_stall  = 1'b0;
        bus.up_flush  = 1'b0;
        bus.sch_stall = 1'b0;
        bus.sch_flush = 1'b0;
        bus.issue     = 1'b0;
        bus.busy_mask = '0;
        if (rst_n) begin
            bus.busy_mask = busy_vec;
            if (bus.ext_stall) begin
                bus.up_stall  = 1'b1;
                bus.sch_stall = 1'b1;
            end else if (flush_req) begin
                bus.up_flush  = 1'b1;
                bus.sch_flush = 1'b1;
            end else if (haz) begin
                bus.up_stall  = 1'b1;
                bus.sch_flush = 1'b1;
            end else begin
                bus.issue = bus.dec_valid;
            end
        end
    end

    always_comb begin
        // A mispredict seen under stall is remembered until the first
        // advancing cycle, which is necessarily the flush cycle.
        pend_flush_d   = bus.ext_stall & (pend_flush_q | bus.alu_mispredict);
        sch_load_vld_d = sch_load_vld_q;
        sch_load_rw_d  = sch_load_rw_q;
        for (int r = 1; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (!bus.ext_stall) begin
            sch_load_vld_d = load_set;
            sch_load_rw_d  = bus.dec_rw_addr;
            for (int r = 1; r < 32; r++) begin
                if (load_set && bus.dec_rw_addr == 5'(r)) begin
                    cnt_d[r] = LAT;
                end else if (flush_take && sch_load_vld_q && sch_load_rw_q == 5'(r)) begin
                    // The flushed load never writes back; release its register.
                    cnt_d[r] = '0;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_flush_q   <= 1'b0;
            sch_load_vld_q <= 1'b0;
            sch_load_rw_q  <= 5'd0;
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            pend_flush_q   <= pend_flush_d;
            sch_load_vld_q <= sch_load_vld_d;
            sch_load_rw_q  <= sch_load_rw_d;
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule
